// File: rtl/sseg_scan_n.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_scan_n
//  Purpose  : Multiplexed N-digit hex seven-segment scanner with per-slot
//             brightness (PWM by phase counter), per-digit blanking, decimal
//             points, leading-zero suppression and a frame-start snapshot of
//             the display inputs.
//  Revision : 1.0  initial release
// ============================================================================
module sseg_scan_n #(
  parameter int DIGITS     = 4,   // number of multiplexed digits, 1..8
  parameter int BRIGHT_W   = 3,   // brightness / phase counter width, 1..6
  parameter int ACTIVE_LOW = 1    // 1: low-true an/ca/dp, 0: high-true
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enabled,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_suppress,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     sseg_an,
  output logic [6:0]            sseg_ca,
  output logic                  sseg_dp,
  output logic                  frame_done
);

  // Index counter needs at least one bit even for a single digit.
  localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PHASE_MAX = '1;
  // XOR mask turning active-high internal values into pin polarity.
  localparam logic              POL       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  // Scan position.
  logic [IDX_W-1:0]    idx;
  logic [BRIGHT_W-1:0] phase;

  // Frame snapshot of the display content.
  logic [4*DIGITS-1:0] shadow_digits;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_blank;
  logic                shadow_lz;

  // Combinational view of the current slot.
  logic                first_slot;
  logic                end_of_frame;
  logic [4*DIGITS-1:0] cur_digits;
  logic [DIGITS-1:0]   cur_dp;
  logic [DIGITS-1:0]   cur_blank;
  logic                cur_lz;
  logic [3:0]          sel_nibble;
  logic                sel_blank;
  logic                sel_dp;
  logic                sel_upper_zero;
  logic                zero_run;
  logic                suppress;
  logic                lit;
  logic [6:0]          seg_code;
  logic [DIGITS-1:0]   an_high;
  logic [6:0]          ca_high;
  logic                dp_high;

  // Hex nibble to active-high gfedcba segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign first_slot   = (idx == '0) && (phase == '0);
  assign end_of_frame = (idx == IDX_LAST) && (phase == PHASE_MAX);

  // The first slot of a frame shows the live inputs (they are being
  // captured on that same edge); every other slot shows the snapshot.
  assign cur_digits = first_slot ? digits      : shadow_digits;
  assign cur_dp     = first_slot ? dp          : shadow_dp;
  assign cur_blank  = first_slot ? blank       : shadow_blank;
  assign cur_lz     = first_slot ? lz_suppress : shadow_lz;

  // Select the active digit and find whether it and every higher digit is zero.
  always_comb begin
    sel_nibble     = 4'h0;
    sel_blank      = 1'b0;
    sel_dp         = 1'b0;
    sel_upper_zero = 1'b0;
    zero_run       = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (cur_digits[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        sel_nibble     = cur_digits[4*i +: 4];
        sel_blank      = cur_blank[i];
        sel_dp         = cur_dp[i];
        sel_upper_zero = zero_run;
      end
    end
  end

  // Build the active-high picture of the slot about to be shown.
  always_comb begin
    lit      = (phase < brightness);
    suppress = cur_lz && (idx != '0) && sel_upper_zero;
    seg_code = hex_to_seg(sel_nibble);
    an_high  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_high[i] = lit && (idx == IDX_W'(i));
    end
    // Forced blank kills dp too; leading-zero suppression keeps dp.
    ca_high = (lit && !sel_blank && !suppress) ? seg_code : 7'h00;
    dp_high = lit && !sel_blank && sel_dp;
  end

  // Scan counters: phase runs fastest, idx advances on each phase wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      phase <= '0;
    end else if (enabled) begin
      if (phase == PHASE_MAX) begin
        phase <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        phase <= phase + 1'b1;
      end
    end
  end

  // Capture display content at the start of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '0;
      shadow_lz     <= 1'b0;
    end else if (enabled && first_slot) begin
      shadow_digits <= digits;
      shadow_dp     <= dp;
      shadow_blank  <= blank;
      shadow_lz     <= lz_suppress;
    end
  end

  // Registered pin drivers, updated only on scan ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      sseg_an <= {DIGITS{POL}};
      sseg_ca <= {7{POL}};
      sseg_dp <= POL;
    end else if (enabled) begin
      sseg_an <= an_high ^ {DIGITS{POL}};
      sseg_ca <= ca_high ^ {7{POL}};
      sseg_dp <= dp_high ^ POL;
    end
  end

  // One-cycle pulse after the last tick of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= enabled && end_of_frame;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_scan_n
//  Purpose  : Self-checking bench for sseg_scan_n (DIGITS=4, BRIGHT_W=2,
//             ACTIVE_LOW=1): vector table, directed corner sequences and a
//             randomized run against a frame-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_scan_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        enabled;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_suppress;
  logic [1:0]  brightness;
  logic [3:0]  sseg_an;
  logic [6:0]  sseg_ca;
  logic        sseg_dp;
  logic        frame_done;

  sseg_scan_n #(.DIGITS(4), .BRIGHT_W(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .enabled(enabled), .digits(digits), .dp(dp),
    .blank(blank), .lz_suppress(lz_suppress), .brightness(brightness),
    .sseg_an(sseg_an), .sseg_ca(sseg_ca), .sseg_dp(sseg_dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position within a 16-tick frame plus the snapshot.
  int          m_pos;
  logic [15:0] s_dg;
  logic [3:0]  s_dp, s_bl;
  logic        s_lz;
  logic [3:0]  e_an;
  logic [6:0]  e_ca;
  logic        e_dp, e_fd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0;
    s_dg = '0; s_dp = '0; s_bl = '0; s_lz = 1'b0;
    e_an = 4'hF; e_ca = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
  endtask

  task automatic model_tick();
    int d, ph, nib;
    logic [15:0] dg;
    logic [3:0]  dpv, bl;
    logic        lzv, lit, supp;
    logic [6:0]  segh;
    d  = m_pos / 4;
    ph = m_pos % 4;
    if (m_pos == 0) begin
      dg = digits; dpv = dp; bl = blank; lzv = lz_suppress;
      s_dg = digits; s_dp = dp; s_bl = blank; s_lz = lz_suppress;
    end else begin
      dg = s_dg; dpv = s_dp; bl = s_bl; lzv = s_lz;
    end
    lit  = (ph < int'(brightness));
    nib  = int'((dg >> (4*d)) & 16'hF);
    supp = lzv && (d > 0) && ((dg >> (4*d)) == 16'h0);
    segh = (bl[d] || supp) ? 7'h00 : seg_tab[nib];
    e_an = lit ? ~(4'(1 << d)) : 4'hF;
    e_ca = lit ? ~segh : 7'h7F;
    e_dp = !(lit && dpv[d] && !bl[d]);
    e_fd = (m_pos == 15);
    m_pos = (m_pos + 1) % 16;
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_an"}, 32'(sseg_an), 32'(e_an));
    check({tag, "_ca"}, 32'(sseg_ca), 32'(e_ca));
    check({tag, "_dp"}, 32'(sseg_dp), 32'(e_dp));
    check({tag, "_fd"}, 32'(frame_done), 32'(e_fd));
  endtask

  // One scan strobe; inputs change only at falling edges.
  task automatic tick();
    enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
    model_tick();
    check_outs("tick");
  endtask

  // A non-strobe cycle: outputs hold, frame_done drops.
  task automatic idle();
    enabled = 1'b0;
    @(negedge clk);
    e_fd = 1'b0;
    check_outs("hold");
  endtask

  task automatic do_reset(input int cycles, input logic with_en);
    rst = 1'b1;
    enabled = with_en;
    repeat (cycles) @(negedge clk);
    model_reset();
    check_outs("reset");
    rst = 1'b0;
    enabled = 1'b0;
  endtask

  typedef struct {
    logic [15:0] dg;
    logic [3:0]  dpi;
    logic        lz;
    logic [3:0]  an;
    logic [6:0]  ca;
    logic        dpo;
    logic        fd;
  } vec_t;

  vec_t tbl [64];

  initial begin
    logic [6:0] ca_f [4][4];
    ca_f[0] = '{7'h40, 7'h79, 7'h24, 7'h30};   // 3210
    ca_f[1] = '{7'h40, 7'h12, 7'h7F, 7'h7F};   // 0050, lz on
    ca_f[2] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};   // 0000, lz on
    ca_f[3] = '{7'h40, 7'h79, 7'h24, 7'h30};   // 3210, dp on digit 2
    for (int f = 0; f < 4; f++) begin
      for (int t = 0; t < 16; t++) begin
        int  d;
        logic on;
        d  = t / 4;
        on = (t % 4) < 3;
        tbl[f*16+t].dg  = (f == 0 || f == 3) ? 16'h3210 : (f == 1) ? 16'h0050 : 16'h0000;
        tbl[f*16+t].dpi = (f == 3) ? 4'b0100 : 4'b0000;
        tbl[f*16+t].lz  = (f == 1 || f == 2);
        tbl[f*16+t].an  = on ? ~(4'(1 << d)) : 4'hF;
        tbl[f*16+t].ca  = on ? ca_f[f][d] : 7'h7F;
        tbl[f*16+t].dpo = !(f == 3 && d == 2 && on);
        tbl[f*16+t].fd  = (t == 15);
      end
    end

    rst = 1'b1; enabled = 1'b0; digits = 16'h0; dp = 4'h0; blank = 4'h0;
    lz_suppress = 1'b0; brightness = 2'd3;
    model_reset();

    // Reset state after two cycles without ticks.
    repeat (2) @(negedge clk);
    check("rst_an", 32'(sseg_an), 32'h0000000F);
    check("rst_ca", 32'(sseg_ca), 32'h0000007F);
    check("rst_dp", 32'(sseg_dp), 32'h1);
    check("rst_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Vector table: basic scan, leading zeros, all-zero, decimal point.
    for (int i = 0; i < 64; i++) begin
      digits = tbl[i].dg; dp = tbl[i].dpi; lz_suppress = tbl[i].lz;
      blank = 4'h0; brightness = 2'd3;
      tick();
      check("tbl_an", 32'(sseg_an), 32'(tbl[i].an));
      check("tbl_ca", 32'(sseg_ca), 32'(tbl[i].ca));
      check("tbl_dp", 32'(sseg_dp), 32'(tbl[i].dpo));
      check("tbl_fd", 32'(frame_done), 32'(tbl[i].fd));
    end
    idle();

    // Snapshot: a mid-frame change is invisible until the next frame.
    digits = 16'h3210; dp = 4'h0; lz_suppress = 1'b0;
    for (int t = 0; t < 16; t++) begin
      if (t == 5) digits = 16'hFFFF;
      tick();
      if (t == 8)  check("snap_d2", 32'(sseg_ca), 32'h24);
      if (t == 12) check("snap_d3", 32'(sseg_ca), 32'h30);
    end
    tick();
    check("snap_new_ca", 32'(sseg_ca), 32'h0E);
    check("snap_new_an", 32'(sseg_an), 32'hE);
    repeat (15) tick();

    // Dark frame: nothing lights, frame_done still pulses.
    brightness = 2'd0;
    for (int t = 0; t < 16; t++) begin
      tick();
      check("dark_an", 32'(sseg_an), 32'hF);
      if (t == 15) check("dark_fd", 32'(frame_done), 32'h1);
    end
    idle();
    idle();

    // Mid-frame reset at idx=2, coincident with a strobe.
    brightness = 2'd3; digits = 16'h3210;
    repeat (9) tick();
    do_reset(1, 1'b1);
    digits = 16'h0007;
    tick();
    check("mrst_an", 32'(sseg_an), 32'hE);
    check("mrst_ca", 32'(sseg_ca), 32'h78);

    // Randomized run against the model.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset(int'($urandom_range(1, 2)), 1'($urandom));
      end else begin
        if (r < 12) begin
          int nz;
          nz = $urandom_range(0, 4);
          digits = 16'($urandom) & 16'((1 << (4*nz)) - 1);
          dp = 4'($urandom);
          blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
          lz_suppress = 1'($urandom);
        end
        if (r < 20) brightness = 2'($urandom);
        if ($urandom_range(0, 2) != 0) tick();
        else idle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/sseg_scan_n.md
SSEG_SCAN_N -- requirements
Module: sseg_scan_n

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL NOT have an asynchronous or active-low reset.
REQ-002 Parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-003 Parameter BRIGHT_W, default 3, width of the brightness input and of the per-digit phase counter; legal range 1..6.
REQ-004 Parameter ACTIVE_LOW, default 1; when 1, sseg_an, sseg_ca and sseg_dp SHALL be driven low-true; when 0, high-true.
REQ-005 Port clk  in  1  system clock; all state SHALL change only on its rising edge.
REQ-006 Port rst  in  1  synchronous active-high reset.
REQ-007 Port enabled  in  1  scan tick strobe; one-cycle pulse, any spacing including back-to-back.
REQ-008 Port digits  in  4*DIGITS  hex nibbles; nibble i occupies bits [4i+3:4i] and drives digit i; digit 0 is rightmost.
REQ-009 Port dp  in  DIGITS  decimal-point request per digit.
REQ-010 Port blank  in  DIGITS  forced-blank mask per digit.
REQ-011 Port lz_suppress  in  1  leading-zero suppression enable.
REQ-012 Port brightness  in  BRIGHT_W  on-time per digit slot, in ticks.
REQ-013 Port sseg_an  out  DIGITS  anode enables; bit i selects digit i.
REQ-014 Port sseg_ca  out  7  segments; bit 0 is a, bit 6 is g.
REQ-015 Port sseg_dp  out  1  decimal-point segment.
REQ-016 Port frame_done  out  1  one-cycle pulse at the end of each full scan.

Function
REQ-017 Counters: phase counts 0..2^BRIGHT_W-1 and idx counts 0..DIGITS-1; both SHALL advance only on cycles where enabled=1.
REQ-018 Advance rule: phase wraps to 0 after its maximum and increments idx; idx wraps from DIGITS-1 to 0.
REQ-019 Outputs SHALL be registered and updated only on enabled cycles, taking their new value one clock after the strobe; between strobes they SHALL hold.
REQ-020 On an enabled cycle at state (idx, phase), the outputs SHALL show digit idx, and at most one anode SHALL be active.
REQ-021 The digit is lit only when phase < brightness; otherwise all anodes, segments and dp SHALL be inactive.
REQ-022 brightness=0 SHALL never light any digit; brightness=2^BRIGHT_W-1 lights all but one tick per slot.
REQ-023 Snapshot: on the enabled cycle at (0,0), digits, dp, blank and lz_suppress SHALL be captured into shadow registers, and that same cycle's output SHALL use the live input values.
REQ-024 All other slots SHALL use the shadow values, so input changes mid-frame are not visible before the next (0,0) tick.
REQ-025 brightness SHALL be used live (not snapshotted).
REQ-026 Segment code, active-high gfedcba, in hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-027 When ACTIVE_LOW=1, segment outputs SHALL be the bitwise complement of this code.
REQ-028 Blanking: a digit with its blank bit set SHALL show no segments and no dp; its anode still follows REQ-021.
REQ-029 Leading-zero suppression: when lz_suppress=1, every digit i>0 whose nibble and all higher nibbles are 0 SHALL be blanked.
REQ-030 Digit 0 SHALL never be suppressed.
REQ-031 A digit suppressed by leading-zero suppression SHALL still light its dp if its dp bit is set.
REQ-032 frame_done SHALL be 1 for exactly one cycle, in the cycle after the enabled tick at (DIGITS-1, 2^BRIGHT_W-1), and 0 otherwise.
REQ-033 DIGITS=1 SHALL work, with idx constant 0 and frame_done marking each phase wrap.

Reset
REQ-034 While rst=1: idx=0, phase=0, shadow registers=0, frame_done=0, and all anodes, segments and dp inactive (ACTIVE_LOW=1: sseg_an all ones, sseg_ca=7'h7F, sseg_dp=1).
REQ-035 rst SHALL take priority over a coincident enabled strobe.
REQ-036 Reset asserted mid-frame SHALL abort the scan; the first tick after release SHALL be the (0,0) tick, including a fresh snapshot.

Verification
REQ-037 Reset test: assert rst for 2 cycles, no ticks -> an=4'b1111, ca=7'h7F, dp=1, frame_done=0.
REQ-038 Basic scan test: DIGITS=4, BRIGHT_W=2, ACTIVE_LOW=1, digits=16'h3210, brightness=3, 16 ticks ->
  - an per tick: 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111.
  - ca per digit: 40, 79, 24, 30.
  - frame_done pulses once after tick 16.
REQ-039 Leading-zero test: lz_suppress=1 with digits=16'h0050 -> digits 3 and 2 blank (ca=7F), digit 1 ca=12, digit 0 ca=40; with digits=16'h0000 only digit 0 shows ca=40.
REQ-040 Snapshot test: change digits from 16'h3210 to 16'hFFFF after tick 5 -> remainder of the frame still shows 2,3; the next frame shows F (ca=0E) on all digits.
REQ-041 Dark and dp test: brightness=0 -> an stays all ones for a full frame while frame_done still pulses; brightness=3, dp=4'b0100 -> sseg_dp=0 only while digit 2 is lit.
REQ-042 Mid-frame reset test: rst for 1 cycle at idx=2, then a tick -> outputs blank during reset; the next tick lights digit 0 with live inputs.
